// File: rtl/deserializer_sipo_if.sv
// Parallel output stream of the SIPO deserializer: word plus valid/ready handshake.
// The deserializer drives the master side; the downstream consumer uses the slave side.
`timescale 1ns/1ps

interface deserializer_sipo_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output data_out,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  data_out,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/deserializer_sipo.sv
// SIPO deserializer: start bit, WIDTH data bits MSB-first, optional even parity
// (enabled by defining PARITY_EN), stop bit; words leave on a valid/ready stream.
`timescale 1ns/1ps

module deserializer_sipo #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic srl_en,
  input  logic srl_in,
  input  logic ovr_clr,
  output logic frame_err,
  output logic par_err,
  output logic overrun,
  output logic busy,
  deserializer_sipo_if.master rx
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
`ifdef PARITY_EN
    ,
    PAR  = 2'd3
`endif
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] data_reg;
  logic             valid_reg;

  logic shift_en;
  logic cnt_clr;
  logic stop_seen;
  logic par_hold;
  logic commit;
  logic frame_hit;
  logic accept;
  logic drop;

`ifdef PARITY_EN
  logic par_cap;
  logic par_bad;
  logic par_hit;

  // Even parity: data bits XOR parity bit must be zero.
  function automatic logic parity_mismatch(input logic [WIDTH-1:0] d, input logic p);
    return (^d) ^ p;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    cnt_clr   = 1'b0;
    stop_seen = 1'b0;
`ifdef PARITY_EN
    par_cap   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (srl_en && !srl_in) begin
          state_nxt = DATA;
          cnt_clr   = 1'b1;
        end
      end
      DATA: begin
        if (srl_en) begin
          shift_en = 1'b1;
          if (cnt == CNT_LAST) begin
`ifdef PARITY_EN
            state_nxt = PAR;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef PARITY_EN
      PAR: begin
        if (srl_en) begin
          par_cap   = 1'b1;
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (srl_en) begin
          stop_seen = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame outcome, decided on the stop-bit strobe
`ifdef PARITY_EN
  assign par_hold = par_bad;
  assign par_hit  = stop_seen && srl_in && par_bad;
`else
  assign par_hold = 1'b0;
`endif
  assign frame_hit = stop_seen && !srl_in;
  assign commit    = stop_seen && srl_in && !par_hold;
  assign accept    = commit && (!valid_reg || rx.out_ready);
  assign drop      = commit && valid_reg && !rx.out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      shreg <= '0;
    end else begin
      if (cnt_clr) begin
        cnt <= '0;
      end else if (shift_en) begin
        cnt <= cnt + CNT_ONE;
      end
      if (shift_en) begin
        shreg <= {shreg[WIDTH-2:0], srl_in};
      end
    end
  end

`ifdef PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bad <= 1'b0;
      par_err <= 1'b0;
    end else begin
      if (par_cap) begin
        par_bad <= parity_mismatch(shreg, srl_in);
      end
      par_err <= par_hit;
    end
  end
`else
  assign par_err = 1'b0;
`endif

  // Output stage: a word is held until consumed; a new word arriving while
  // the old one is still pending is dropped and flagged as overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_hit;
      if (accept) begin
        data_reg  <= shreg;
        valid_reg <= 1'b1;
      end else if (valid_reg && rx.out_ready) begin
        valid_reg <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  assign rx.data_out  = data_reg;
  assign rx.out_valid = valid_reg;
  assign busy         = (state != IDLE);

endmodule

// File: doc/deserializer_sipo.md
# deserializer_sipo

Serial-in, parallel-out (SIPO) deserializer that receives the framed bit stream produced by the team's PISO serializer and rebuilds parallel words. A one-bit strobe qualifies each serial bit. The block detects start and stop bits, checks framing and optional parity, and presents each word on a valid/ready handshake to downstream logic. It sits at the receive end of the serial link, directly after the line/bit-timing logic.

## Interface
- WIDTH, 8, data word width in bits (≥2)
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- srl_en  in  1  bit strobe; srl_in sampled only on cycles with srl_en=1
- srl_in  in  1  serial data; line idles high
- data_out  out  WIDTH  last accepted word
- out_valid  out  1  data_out holds an unconsumed word
- out_ready  in  1  consumer accepts word when out_valid & out_ready
- frame_err  out  1  one-cycle pulse: stop bit sampled as 0
- par_err  out  1  one-cycle pulse: parity mismatch (constant 0 without PARITY_EN)
- overrun  out  1  sticky: completed word dropped because previous word not consumed
- ovr_clr  in  1  clears overrun
- busy  out  1  high in any state other than IDLE

## Operation
- Frame: start bit (0), WIDTH data bits MSB-first, [parity bit], stop bit (1). All bits are counted in srl_en strobes only.
- FSM states are IDLE, DATA, PAR, STOP. PAR exists only with PARITY_EN.
- IDLE: on a strobe with srl_in=0, go to DATA and set bit counter=0. On a strobe with srl_in=1, stay in IDLE.
- DATA: on each strobe, shreg <= {shreg[WIDTH-2:0], srl_in} and counter increments. The strobe that captures bit WIDTH-1 goes to PAR, or to STOP when parity is disabled.
- PAR: on a strobe, latch the parity mismatch (even parity: XOR of data bits ^ srl_in must be 0), then go to STOP.
- STOP, on a strobe, always returns to IDLE:
  - srl_in=0: frame_err pulses and the word is discarded.
  - srl_in=1 with parity mismatch: par_err pulses and the word is discarded.
  - otherwise the word is committed.
- Commit:
  - If out_valid=0, or out_valid & out_ready in the same cycle: data_out <= shreg and out_valid <= 1.
  - Otherwise the new word is dropped, data_out is unchanged, and overrun <= 1.
- Handshake: out_valid falls on the edge where out_valid & out_ready, unless a commit occurs in the same cycle. data_out is stable while out_valid=1.
- overrun: set has priority over ovr_clr in the same cycle. overrun is otherwise cleared by ovr_clr=1.
- Strobes are never skipped. Gaps between strobes of any length do not disturb frame state.

## Timing
- Reset (rst=0, asynchronous) takes effect immediately:
  - state=IDLE, counter=0, shreg=0.
  - data_out=0, out_valid=0, frame_err=0, par_err=0, overrun=0, busy=0.
- Reset mid-frame discards the partial word. The first start bit after rst is released begins a new frame.
- Latency with continuous srl_en:
  - Parity disabled: start bit sampled at edge 0; stop bit sampled at edge WIDTH+1; out_valid=1 and data_out valid after that edge.
  - Parity enabled: one more cycle.
- frame_err and par_err are high for exactly the one cycle after the stop-bit edge.
- busy goes high on the edge that samples the start bit and low on the stop-bit edge.
- Back-to-back frames are supported: a start bit may be sampled on the strobe immediately after the stop bit.

## Configuration
- PARITY_EN defined:
  - PAR state present; one even-parity bit follows the data bits.
  - A mismatch pulses par_err and discards the word.
- PARITY_EN undefined:
  - No parity bit; STOP follows DATA directly.
  - par_err is tied to 0.

## Test plan
- srl_en=1 continuously, WIDTH=8, frame 0,1,0,1,0,0,1,0,1,1 (0xA5) -> out_valid=1 after edge 9, data_out=0xA5, frame_err=0, busy low after edge 9.
- Same frame with stop bit 0 -> frame_err pulses one cycle, out_valid stays 0, FSM back in IDLE and accepts a following 0x3C frame.
- Frames 0x3C then 0xC3 with out_ready=0 -> data_out stays 0x3C and overrun=1. Pulse ovr_clr -> overrun=0. Then out_ready=1 -> out_valid falls.
- srl_en high only every 3rd cycle, frame 0x5A with srl_in changing between strobes -> data_out=0x5A and out_valid set on the stop-strobe edge.
- rst pulsed low after 4 data bits -> all outputs 0 immediately; next frame 0xFF -> data_out=0xFF.
- PARITY_EN, data 0xA5 with parity bit 1 -> par_err pulse and no out_valid. Parity bit 0 -> data_out=0xA5 and out_valid=1.
